// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler: builds 3-byte packets from the byte receiver,
// decodes buttons/deltas and tracks a clamped cursor position.
module ps2_mouse_packet #(
    parameter int TIMEOUT_CYC = 200_000,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [1:0] ovf,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       sync_err
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [11:0] X_LIM = 12'(X_MAX);
    localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);
    localparam logic [9:0] X_RST = 10'((X_MAX + 1) / 2);
    localparam logic [9:0] Y_RST = 10'((Y_MAX + 1) / 2);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Fields of byte0 kept until the packet completes
    logic [2:0] b0_btn;
    logic       b0_xs;
    logic       b0_ys;
    logic [1:0] b0_ovf;
    logic [7:0] b1;

    logic               expire;
    logic [8:0]         dx_n;
    logic [8:0]         dy_n;
    logic signed [11:0] dx_e;
    logic signed [11:0] dy_e;
    logic signed [11:0] x_sum;
    logic signed [11:0] y_sum;
    logic [9:0]         x_n;
    logic [9:0]         y_n;

    // Timeout detection and next-position arithmetic with clamping
    always_comb begin
        expire = (state != WAIT_B0) && !rx_done && (cnt == CNT_LAST);
        dx_n   = {b0_xs, b1};
        dy_n   = {b0_ys, rx_data};
        dx_e   = b0_ovf[0] ? 12'sd0 : {{3{dx_n[8]}}, dx_n};
        dy_e   = b0_ovf[1] ? 12'sd0 : {{3{dy_n[8]}}, dy_n};
        x_sum  = $signed({2'b00, x_pos}) + dx_e;
        y_sum  = $signed({2'b00, y_pos}) - dy_e;
        if (x_sum < 0)
            x_n = '0;
        else if (x_sum > X_LIM)
            x_n = X_LIM[9:0];
        else
            x_n = x_sum[9:0];
        if (y_sum < 0)
            y_n = '0;
        else if (y_sum > Y_LIM)
            y_n = Y_LIM[9:0];
        else
            y_n = y_sum[9:0];
    end

    // Packet FSM, timeout counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_B0;
            cnt       <= '0;
            b0_btn    <= '0;
            b0_xs     <= 1'b0;
            b0_ys     <= 1'b0;
            b0_ovf    <= '0;
            b1        <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            btn       <= '0;
            ovf       <= '0;
            dx        <= '0;
            dy        <= '0;
            x_pos     <= X_RST;
            y_pos     <= Y_RST;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (rx_done || state == WAIT_B0 || expire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            unique case (state)
                WAIT_B0: begin
                    if (rx_done) begin
                        if (rx_data[3]) begin
                            b0_btn <= rx_data[2:0];
                            b0_xs  <= rx_data[4];
                            b0_ys  <= rx_data[5];
                            b0_ovf <= rx_data[7:6];
                            state  <= WAIT_B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (rx_done) begin
                        b1    <= rx_data;
                        state <= WAIT_B2;
                    end else if (expire) begin
                        sync_err <= 1'b1;
                        state    <= WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (rx_done) begin
                        btn       <= b0_btn;
                        ovf       <= b0_ovf;
                        dx        <= dx_n;
                        dy        <= dy_n;
                        x_pos     <= x_n;
                        y_pos     <= y_n;
                        pkt_valid <= 1'b1;
                        state     <= WAIT_B0;
                    end else if (expire) begin
                        sync_err <= 1'b1;
                        state    <= WAIT_B0;
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet with a packet scoreboard
// and a reference cursor model.
module tb_ps2_mouse_packet;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [1:0] ovf;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       sync_err;

    typedef struct {
        logic [2:0] btn;
        logic [1:0] ovf;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mx = 320;
    int   my = 240;

    ps2_mouse_packet #(
        .TIMEOUT_CYC(T),
        .X_MAX(639),
        .Y_MAX(479)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .pkt_valid(pkt_valid),
        .btn      (btn),
        .ovf      (ovf),
        .dx       (dx),
        .dy       (dy),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; rx_done sampled at the next posedge
    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic idle(input int n, output int errs);
        errs = 0;
        repeat (n) begin
            @(negedge clk);
            if (sync_err === 1'b1)
                errs++;
        end
    endtask

    task automatic expect_pkt(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
        exp_t e;
        int   dxi;
        int   dyi;
        dxi = b0[4] ? int'(b1) - 256 : int'(b1);
        dyi = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) begin
            mx = mx + dxi;
            if (mx < 0) mx = 0;
            if (mx > 639) mx = 639;
        end
        if (!b0[7]) begin
            my = my - dyi;
            if (my < 0) my = 0;
            if (my > 479) my = 479;
        end
        e.btn = b0[2:0];
        e.ovf = b0[7:6];
        e.dx  = 9'(dxi);
        e.dy  = 9'(dyi);
        e.x   = 10'(mx);
        e.y   = 10'(my);
        sb.push_back(e);
    endtask

    // Pops one expected packet when pkt_valid is seen
    task automatic check_pkt(input string tag);
        exp_t e;
        chk({tag, ".pkt_valid"}, 32'(pkt_valid), 32'd1);
        chk({tag, ".sync_err"}, 32'(sync_err), 32'd0);
        if (pkt_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".btn"}, 32'(btn), 32'(e.btn));
            chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
            chk({tag, ".dx"}, 32'(dx), 32'(e.dx));
            chk({tag, ".dy"}, 32'(dy), 32'(e.dy));
            chk({tag, ".x"}, 32'(x_pos), 32'(e.x));
            chk({tag, ".y"}, 32'(y_pos), 32'(e.y));
        end
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        expect_pkt(b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        check_pkt(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".x"}, 32'(x_pos), 32'd320);
        chk({tag, ".y"}, 32'(y_pos), 32'd240);
        chk({tag, ".btn"}, 32'(btn), 32'd0);
        chk({tag, ".dx"}, 32'(dx), 32'd0);
        chk({tag, ".dy"}, 32'(dy), 32'd0);
        chk({tag, ".pv"}, 32'(pkt_valid), 32'd0);
        chk({tag, ".se"}, 32'(sync_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mx = 320;
        my = 240;
        sb.delete();
        #1;
        chk("rst_async.x", 32'(x_pos), 32'd320);
        chk("rst_async.y", 32'(y_pos), 32'd240);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int errs;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Basic packet, left button
        send_pkt("basic", 8'h09, 8'h05, 8'h03);
        @(negedge clk);
        chk("basic.pv_low", 32'(pkt_valid), 32'd0);
        chk("basic.hold_x", 32'(x_pos), 32'd325);

        // Large negative deltas, clamping on both axes
        do_reset();
        send_pkt("neg1", 8'h38, 8'h80, 8'h80);
        send_pkt("neg2", 8'h38, 8'h80, 8'h80);
        send_pkt("neg3", 8'h38, 8'h80, 8'h80);

        // Out-of-sync byte dropped
        do_reset();
        send_byte(8'h00);
        chk("drop.sync_err", 32'(sync_err), 32'd1);
        chk("drop.pv", 32'(pkt_valid), 32'd0);
        send_pkt("after_drop", 8'h08, 8'h02, 8'h00);

        // Inter-byte timeout discards partial packet
        do_reset();
        send_byte(8'h08);
        send_byte(8'h10);
        idle(T, errs);
        chk("tmo.sync_err", 32'(sync_err), 32'd1);
        chk("tmo.pv", 32'(pkt_valid), 32'd0);
        @(negedge clk);
        chk("tmo.pulse_end", 32'(sync_err), 32'd0);
        send_pkt("after_tmo", 8'h08, 8'h01, 8'h01);

        // Byte coincident with expiry keeps the packet alive
        expect_pkt(8'h08, 8'h01, 8'h01);
        send_byte(8'h08);
        idle(T - 1, errs);
        chk("coinc.idle_err", 32'(errs), 32'd0);
        send_byte(8'h01);
        chk("coinc.no_err", 32'(sync_err), 32'd0);
        send_byte(8'h01);
        check_pkt("coinc");

        // X overflow: raw delta reported, position untouched
        do_reset();
        send_pkt("ovf", 8'h48, 8'h10, 8'h00);

        // Reset in the middle of a packet
        send_pkt("pre_mid", 8'h09, 8'h05, 8'h03);
        send_byte(8'h08);
        send_byte(8'h20);
        do_reset();
        check_reset_vals("mid_rst");
        send_pkt("fresh", 8'h09, 8'h05, 8'h03);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Outputs that must never coincide
    always @(negedge clk) begin
        if (reset)
            assert (!(pkt_valid === 1'b1 && sync_err === 1'b1))
            else $error("FAIL excl pkt_valid=%0d sync_err=%0d", pkt_valid, sync_err);
    end

endmodule
